alu_exec_unit: RTL

- 16-bit execute-stage ALU. Consumes the 3-bit ALU control code from the ALU control decoder, plus two operands.
- Returns a registered result with flags over a valid/ready handshake.
- Single-cycle ops (AND, OR, ADD, SUB, SLT) complete in one cycle. MUL runs on an iterative 16-cycle shift-add engine.
- Sits between the ALU control decoder / register-read stage and the MEM/WB stage.

---
 rtl/alu_exec_if.sv | 27 ++
 rtl/alu_exec_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/alu_exec_if.sv
// Request/response bundle between the register-read stage, the execute ALU
// and the MEM/WB stage: valid/ready on both sides plus operands and flags.
interface alu_exec_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, overflow, illegal
    );

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, overflow, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB/SLT, iterative shift-add MUL,
// registered result and flags held until the consumer takes them.
module alu_exec_unit #(
    parameter int WIDTH = 16
) (
    input logic      clock,
    input logic      reset_n,
    alu_exec_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               ill_q, ill_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic               alu_ill;
    logic [WIDTH-1:0]   add_r;
    logic [WIDTH-1:0]   sub_r;
    logic [2*WIDTH-1:0] acc_sum;

    assign add_r   = bus.op_a + bus.op_b;
    assign sub_r   = bus.op_a - bus.op_b;
    assign acc_sum = mplier_q[0] ? acc_q + mcand_q : acc_q;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        unique case (bus.alu_ctrl)
            OP_AND: alu_res = bus.op_a & bus.op_b;
            OP_OR:  alu_res = bus.op_a | bus.op_b;
            OP_ADD: begin
                alu_res = add_r;
                alu_ovf = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1])
                        && (add_r[WIDTH-1] != bus.op_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_r;
                alu_ovf = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1])
                        && (sub_r[WIDTH-1] != bus.op_a[WIDTH-1]);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}},
                               $signed(bus.op_a) < $signed(bus.op_b)};
            OP_MUL: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.alu_ctrl == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, bus.op_a};
                        mplier_d = bus.op_b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        ill_d    = 1'b0;
                        state_d  = BUSY;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        ill_d    = alu_ill;
                        state_d  = HOLD;
                    end
                end
            end
            BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // last iteration: publish straight from the adder output
                if (cnt_q == CW'(WIDTH-1)) begin
                    result_d = acc_sum[WIDTH-1:0];
                    zero_d   = (acc_sum[WIDTH-1:0] == '0);
                    ovf_d    = |acc_sum[2*WIDTH-1:WIDTH];
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.illegal   = ill_q;
endmodule
